// File: rtl/bg_fb_pkg.sv
// Shared geometry and writer state encoding for the 400x300 4-bit background framebuffer.
// The reader stage imports the same geometry.
package bg_fb_pkg;

   localparam int unsigned H_RES     = 400;
   localparam int unsigned V_RES     = 300;
   localparam int unsigned FB_ADDR_W = 22;
   localparam int unsigned FB_DATA_W = 4;
   localparam int unsigned FB_SIZE   = H_RES * V_RES;

   typedef enum logic [1:0] {
      StIdle,
      StStream,
      StDone
   } bg_wr_state_e;

   // Edge sums are formed one bit wider than the operands so they cannot wrap.
   function automatic logic rect_fits(logic [9:0] x0, logic [8:0] y0,
                                      logic [9:0] width, logic [8:0] height);
      logic [10:0] x_end;
      logic [9:0]  y_end;
      x_end = {1'b0, x0} + {1'b0, width};
      y_end = {1'b0, y0} + {1'b0, height};
      return (width != '0) && (height != '0) &&
             (x_end <= 11'(H_RES)) && (y_end <= 10'(V_RES));
   endfunction

endpackage

// File: rtl/bg_rect_addr_gen.sv
// Raster address generator for one rectangle: column/row counters, the row base
// address and a flag marking the final pixel.
module bg_rect_addr_gen
   import bg_fb_pkg::*;
(
   input  logic                 pclk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 step,
   input  logic [9:0]           x0,
   input  logic [8:0]           y0,
   input  logic [9:0]           width,
   input  logic [8:0]           height,
   output logic [FB_ADDR_W-1:0] addr,
   output logic                 last
);

   logic [9:0]           w_q;
   logic [8:0]           h_q;
   logic [9:0]           cx_q;
   logic [8:0]           cy_q;
   logic [FB_ADDR_W-1:0] row_base_q;
   logic                 row_end;

   assign row_end = (cx_q == w_q - 10'd1);
   assign last    = row_end && (cy_q == h_q - 9'd1);
   assign addr    = row_base_q + FB_ADDR_W'(cx_q);

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         w_q        <= '0;
         h_q        <= '0;
         cx_q       <= '0;
         cy_q       <= '0;
         row_base_q <= '0;
      end else if (load) begin
         w_q        <= width;
         h_q        <= height;
         cx_q       <= '0;
         cy_q       <= '0;
         row_base_q <= FB_ADDR_W'(y0) * FB_ADDR_W'(H_RES) + FB_ADDR_W'(x0);
      end else if (step) begin
         if (row_end) begin
            // Past the last row the base points one row beyond the rectangle; never used.
            cx_q       <= '0;
            cy_q       <= cy_q + 9'd1;
            row_base_q <= row_base_q + FB_ADDR_W'(H_RES);
         end else begin
            cx_q <= cx_q + 10'd1;
         end
      end
   end

endmodule

// File: rtl/bg_rect_writer.sv
// Rectangle writer into the background framebuffer: command in, raster pixel stream in,
// one write per pixel. Define BG_RECT_WRITER_VBLANK_GATE_EN to accept pixels only in vblank.
module bg_rect_writer
   import bg_fb_pkg::*;
(
   input  logic                 pclk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [9:0]           x0,
   input  logic [8:0]           y0,
   input  logic [9:0]           width,
   input  logic [8:0]           height,
   input  logic [FB_DATA_W-1:0] pix_data,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   input  logic                 vblnk_in,
   output logic                 wr_en,
   output logic [FB_ADDR_W-1:0] wr_addr,
   output logic [FB_DATA_W-1:0] wr_data,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   bg_wr_state_e         state_q;
   logic                 wr_en_q;
   logic [FB_ADDR_W-1:0] wr_addr_q;
   logic [FB_DATA_W-1:0] wr_data_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 err_q;

   logic                 cmd_ok;
   logic                 load;
   logic                 accept;
   logic [FB_ADDR_W-1:0] gen_addr;
   logic                 gen_last;

`ifdef BG_RECT_WRITER_VBLANK_GATE_EN
   assign pix_ready = (state_q == StStream) && vblnk_in;
`else
   logic unused_vblnk;
   assign unused_vblnk = vblnk_in;
   assign pix_ready    = (state_q == StStream);
`endif

   assign cmd_ok = rect_fits(x0, y0, width, height);
   assign load   = (state_q == StIdle) && start && cmd_ok;
   // Abort wins over a same-cycle handshake, so the counters must not advance either.
   assign accept = pix_valid && pix_ready && !abort;

   bg_rect_addr_gen u_addr_gen (
      .pclk   (pclk),
      .rst_n  (rst_n),
      .load   (load),
      .step   (accept),
      .x0     (x0),
      .y0     (y0),
      .width  (width),
      .height (height),
      .addr   (gen_addr),
      .last   (gen_last)
   );

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (cmd_ok) begin
                     state_q <= StStream;
                     busy_q  <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            StStream: begin
               if (abort) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else if (accept) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= gen_addr;
                  wr_data_q <= pix_data;
                  if (gen_last) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;

endmodule

// File: tb/tb_bg_rect_writer.sv
// Randomised scoreboard bench for bg_rect_writer; expected writes come from the
// raster formula addr = (y0 + k / w) * 400 + x0 + k % w for the k-th accepted pixel.
module tb_bg_rect_writer;

`ifdef BG_RECT_WRITER_VBLANK_GATE_EN
   localparam bit Gate = 1'b1;
`else
   localparam bit Gate = 1'b0;
`endif

   logic        pclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [9:0]  x0 = '0;
   logic [8:0]  y0 = '0;
   logic [9:0]  width = '0;
   logic [8:0]  height = '0;
   logic [3:0]  pix_data = '0;
   logic        pix_valid = 1'b0;
   logic        vblnk_in = 1'b0;
   logic        pix_ready;
   logic        wr_en;
   logic [21:0] wr_addr;
   logic [3:0]  wr_data;
   logic        busy;
   logic        done;
   logic        err;

   bg_rect_writer dut (
      .pclk      (pclk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .x0        (x0),
      .y0        (y0),
      .width     (width),
      .height    (height),
      .pix_data  (pix_data),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .vblnk_in  (vblnk_in),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      int addr;
      int data;
      bit last;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   wr_cnt = 0;
   bit   err_ok = 1'b0;
   int   last_addr = 0;
   int   last_data = 0;
   exp_t mon_e;

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
      end
   endtask

   // Monitor: every write must match the head of the queue; between writes outputs hold.
   always @(negedge pclk) begin
      if (rst_n) begin
         if (wr_en) begin
            wr_cnt++;
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got addr %0d want none", wr_addr);
            end else begin
               mon_e = q.pop_front();
               check("wr_addr", int'(wr_addr), mon_e.addr);
               check("wr_data", int'(wr_data), mon_e.data);
               check("done_on_write", int'(done), int'(mon_e.last));
               last_addr = mon_e.addr;
               last_data = mon_e.data;
            end
         end else begin
            check("addr_hold", int'(wr_addr), last_addr);
            check("data_hold", int'(wr_data), last_data);
            check("done_idle", int'(done), 0);
         end
         if (!err_ok) check("err_quiet", int'(err), 0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cmd(input int x, input int y, input int w, input int h);
      start = 1'b1;
      x0 = 10'(x);
      y0 = 9'(y);
      width = 10'(w);
      height = 9'(h);
      @(negedge pclk);
      start = 1'b0;
      check("busy_after_start", int'(busy), 1);
   endtask

   task automatic reject(input int x, input int y, input int w, input int h);
      err_ok = 1'b1;
      start = 1'b1;
      x0 = 10'(x);
      y0 = 9'(y);
      width = 10'(w);
      height = 9'(h);
      @(negedge pclk);
      start = 1'b0;
      check("err_pulse", int'(err), 1);
      check("busy_on_reject", int'(busy), 0);
      check("ready_on_reject", int'(pix_ready), 0);
      @(negedge pclk);
      check("err_one_cycle", int'(err), 0);
      err_ok = 1'b0;
   endtask

   // Drives the pixel stream; abort_at / stop_at < 0 disable those exits.
   task automatic stream(input int x, input int y, input int w, input int h, input int p,
                         input int abort_at, input int stop_at, input bit seq,
                         input bit junk_start);
      int       acc = 0;
      int       cyc = 0;
      bit       v;
      bit       vb;
      bit       rdy;
      logic [3:0] d;
      exp_t     e;
      while (acc < w * h) begin
         if (abort_at >= 0 && acc == abort_at) begin
            abort = 1'b1;
            pix_valid = 1'b1;
            pix_data = 4'($urandom);
            vblnk_in = 1'($urandom);
            @(negedge pclk);
            abort = 1'b0;
            pix_valid = 1'b0;
            start = 1'b0;
            return;
         end
         if (stop_at >= 0 && acc == stop_at) break;
         if (cyc++ > 20000) begin
            check("stream_timeout", acc, w * h);
            break;
         end
         v = ($urandom_range(99) < p);
         vb = 1'($urandom);
         rdy = Gate ? vb : 1'b1;
         d = seq ? 4'(acc + 1) : 4'($urandom);
         pix_valid = v;
         pix_data = d;
         vblnk_in = vb;
         if (junk_start) begin
            start = 1'($urandom);
            x0 = 10'($urandom);
            y0 = 9'($urandom);
            width = 10'($urandom);
            height = 9'($urandom);
         end
         #1;
         check("pix_ready", int'(pix_ready), int'(rdy));
         if (v && rdy) begin
            e.addr = (y + acc / w) * 400 + x + acc % w;
            e.data = int'(d);
            e.last = (acc == w * h - 1);
            q.push_back(e);
            acc++;
         end
         @(negedge pclk);
      end
      pix_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic finish_rect();
      @(negedge pclk);
      check("busy_after_done", int'(busy), 0);
      check("ready_after_done", int'(pix_ready), 0);
      check("queue_drained", q.size(), 0);
   endtask

   task automatic full_rect(input int x, input int y, input int w, input int h, input int p);
      cmd(x, y, w, h);
      stream(x, y, w, h, p, -1, -1, 1'b0, 1'b0);
      finish_rect();
   endtask

   initial begin
      int base;
      int rw;
      int rh;
      int rx;
      int ry;

      repeat (3) @(negedge pclk);
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_wr_addr", int'(wr_addr), 0);
      check("rst_wr_data", int'(wr_data), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      check("rst_ready", int'(pix_ready), 0);
      rst_n = 1'b1;
      @(negedge pclk);
      check("idle_busy", int'(busy), 0);
      check("idle_ready", int'(pix_ready), 0);

      // Small rect with known data 1..6 at (10,2).
      cmd(10, 2, 3, 2);
      stream(10, 2, 3, 2, 100, -1, -1, 1'b1, 1'b0);
      finish_rect();

      reject(398, 0, 3, 1);
      reject(5, 5, 0, 4);
      reject(5, 5, 4, 0);
      reject(0, 299, 1, 2);
      reject(1023, 511, 1023, 511);

      full_rect(397, 0, 3, 1, 100);

      base = wr_cnt;
      full_rect(0, 0, 4, 4, 50);
      check("bubble_write_count", wr_cnt - base, 16);

      // Abort after five pixels, then an immediate new command with junk starts mid-stream.
      base = wr_cnt;
      cmd(0, 0, 10, 10);
      stream(0, 0, 10, 10, 100, 5, -1, 1'b0, 1'b0);
      check("abort_busy", int'(busy), 0);
      check("abort_ready", int'(pix_ready), 0);
      check("abort_queue", q.size(), 0);
      check("abort_write_count", wr_cnt - base, 5);
      cmd(2, 3, 5, 3);
      stream(2, 3, 5, 3, 80, -1, -1, 1'b0, 1'b1);
      finish_rect();

      full_rect(0, 295, 400, 5, 90);
      full_rect(396, 299, 4, 1, 100);

      repeat (12) begin
         rw = $urandom_range(12, 1);
         rh = $urandom_range(6, 1);
         rx = $urandom_range(400 - rw, 0);
         ry = $urandom_range(300 - rh, 0);
         full_rect(rx, ry, rw, rh, 70);
      end

      // Reset in the middle of a rectangle.
      cmd(20, 20, 8, 8);
      stream(20, 20, 8, 8, 100, -1, 5, 1'b0, 1'b0);
      @(negedge pclk);
      check("pre_reset_busy", int'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_wr_en", int'(wr_en), 0);
      check("mid_rst_wr_addr", int'(wr_addr), 0);
      check("mid_rst_wr_data", int'(wr_data), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_done", int'(done), 0);
      check("mid_rst_err", int'(err), 0);
      check("mid_rst_ready", int'(pix_ready), 0);
      q.delete();
      last_addr = 0;
      last_data = 0;
      @(negedge pclk);
      #2;
      rst_n = 1'b1;
      @(negedge pclk);
      check("post_rst_busy", int'(busy), 0);
      full_rect(0, 0, 2, 2, 100);

      repeat (2) @(negedge pclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
